// File: rtl/dcpu_bus_pkg.sv
// Shared definitions for the dcpu bus controller: FSM states, decode
// region codes and the value returned on an aborted IO read.
package dcpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_RAM_WT,
    ST_IO_REQ,
    ST_ACK
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_IO
  } region_t;

  // Data returned to the core when an IO access times out.
  localparam logic [15:0] ERR_RD_DATA = 16'hFFFF;

endpackage

// File: rtl/dcpu_bus_decode.sv
// Combinational address decoder: classifies a core word address as RAM,
// IO window or unmapped, and produces the 8-bit offset into the IO window.
// The IO window wins when it overlaps the RAM range.
module dcpu_bus_decode
  import dcpu_bus_pkg::*;
#(
  parameter int          RAM_AW  = 12,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic [15:0] addr,
  output region_t     region,
  output logic [7:0]  io_offset
);

  localparam logic [31:0] RAM_WORDS = 32'(1) << RAM_AW;
  localparam logic [16:0] IO_TOP    = {1'b0, IO_BASE} + 17'd255;

  logic in_ram;
  logic in_io;

  assign in_ram = ({16'd0, addr} < RAM_WORDS);
  assign in_io  = ({1'b0, addr} >= {1'b0, IO_BASE}) && ({1'b0, addr} <= IO_TOP);

  // The low byte of (addr - IO_BASE) only depends on the low bytes.
  assign io_offset = addr[7:0] - IO_BASE[7:0];

  // Region priority: IO window first, then RAM, otherwise unmapped.
  always_comb begin
    region = REG_NONE;
    if (in_io) begin
      region = REG_IO;
    end else if (in_ram) begin
      region = REG_RAM;
    end
  end

endmodule

// File: rtl/dcpu_bus_ctrl.sv
// Bus controller between the dcpu memory port and the on-chip RAM / IO bus.
// One access outstanding at a time. Every output is a register; the
// combinational process computes the next value of each of them.
//   RAM read : ack in cycle N+3+RAM_WAIT (N = cycle the request is seen)
//   RAM write: ack in cycle N+2 (RAM_WT is the single issue cycle)
//   unmapped : ack in cycle N+2, also routed through RAM_WT, no strobes
//   IO       : strobe held until i_io_ack or IO_TMO cycles elapse
module dcpu_bus_ctrl
  import dcpu_bus_pkg::*;
#(
  parameter int          RAM_AW   = 12,
  parameter logic [15:0] IO_BASE  = 16'hFF00,
  parameter int          RAM_WAIT = 0,    // 0..254
  parameter int          IO_TMO   = 15    // 1..255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [15:0]       i_addr,
  input  logic [15:0]       i_dat,
  output logic [15:0]       o_dat,
  output logic              o_ack,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [15:0]       o_ram_dat,
  input  logic [15:0]       i_ram_dat,
  output logic              o_io_stb,
  output logic              o_io_we,
  output logic [7:0]        o_io_addr,
  output logic [15:0]       o_io_dat,
  input  logic [15:0]       i_io_dat,
  input  logic              i_io_ack,
  input  logic              i_err_clr,
  output logic              o_err_unmap,
  output logic              o_err_tmo
);

  // RAM_RD spends one cycle with the enable out, one cycle for the RAM
  // latency, plus RAM_WAIT extra cycles; capture happens at count RAM_LAST.
  localparam logic [7:0] RAM_LAST = 8'(RAM_WAIT + 1);
  // The strobe is high for IO_TMO cycles: counts 0 .. IO_TMO-1.
  localparam logic [7:0] IO_LAST  = 8'(IO_TMO - 1);

  state_t            state_reg,     state_next;
  logic [7:0]        cnt_reg,       cnt_next;
  logic [15:0]       dat_reg,       dat_next;
  logic              ack_reg,       ack_next;
  logic              ram_en_reg,    ram_en_next;
  logic              ram_we_reg,    ram_we_next;
  logic [RAM_AW-1:0] ram_addr_reg,  ram_addr_next;
  logic [15:0]       ram_dat_reg,   ram_dat_next;
  logic              io_stb_reg,    io_stb_next;
  logic              io_we_reg,     io_we_next;
  logic [7:0]        io_addr_reg,   io_addr_next;
  logic [15:0]       io_dat_reg,    io_dat_next;
  logic              err_unmap_reg, err_unmap_next;
  logic              err_tmo_reg,   err_tmo_next;

  region_t    region;
  logic [7:0] io_offset;

  dcpu_bus_decode #(
    .RAM_AW  (RAM_AW),
    .IO_BASE (IO_BASE)
  ) u_decode (
    .addr      (i_addr),
    .region    (region),
    .io_offset (io_offset)
  );

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      dat_reg       <= '0;
      ack_reg       <= 1'b0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_dat_reg   <= '0;
      io_stb_reg    <= 1'b0;
      io_we_reg     <= 1'b0;
      io_addr_reg   <= '0;
      io_dat_reg    <= '0;
      err_unmap_reg <= 1'b0;
      err_tmo_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      dat_reg       <= dat_next;
      ack_reg       <= ack_next;
      ram_en_reg    <= ram_en_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_dat_reg   <= ram_dat_next;
      io_stb_reg    <= io_stb_next;
      io_we_reg     <= io_we_next;
      io_addr_reg   <= io_addr_next;
      io_dat_reg    <= io_dat_next;
      err_unmap_reg <= err_unmap_next;
      err_tmo_reg   <= err_tmo_next;
    end
  end

  // Next-state and next-output logic; error sets override a same-cycle clear.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    dat_next       = dat_reg;
    ram_en_next    = 1'b0;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_dat_next   = ram_dat_reg;
    io_stb_next    = io_stb_reg;
    io_we_next     = io_we_reg;
    io_addr_next   = io_addr_reg;
    io_dat_next    = io_dat_reg;
    err_unmap_next = i_err_clr ? 1'b0 : err_unmap_reg;
    err_tmo_next   = i_err_clr ? 1'b0 : err_tmo_reg;

    case (state_reg)
      ST_IDLE: begin
        if (i_cs) begin
          cnt_next = '0;
          case (region)
            REG_RAM: begin
              ram_en_next   = 1'b1;
              ram_we_next   = i_we;
              ram_addr_next = i_addr[RAM_AW-1:0];
              ram_dat_next  = i_dat;
              state_next    = i_we ? ST_RAM_WT : ST_RAM_RD;
            end
            REG_IO: begin
              io_stb_next  = 1'b1;
              io_we_next   = i_we;
              io_addr_next = io_offset;
              io_dat_next  = i_dat;
              state_next   = ST_IO_REQ;
            end
            default: begin
              dat_next       = '0;
              err_unmap_next = 1'b1;
              state_next     = ST_RAM_WT;
            end
          endcase
        end
      end

      ST_RAM_RD: begin
        if (cnt_reg == RAM_LAST) begin
          dat_next   = i_ram_dat;
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ST_RAM_WT: begin
        state_next = ST_ACK;
      end

      ST_IO_REQ: begin
        if (i_io_ack) begin
          dat_next    = io_we_reg ? 16'h0000 : i_io_dat;
          io_stb_next = 1'b0;
          state_next  = ST_ACK;
        end else if (cnt_reg == IO_LAST) begin
          dat_next     = ERR_RD_DATA;
          io_stb_next  = 1'b0;
          err_tmo_next = 1'b1;
          state_next   = ST_ACK;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      // The core still holds the old request here, so i_cs is not looked at.
      ST_ACK: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    ack_next = (state_next == ST_ACK);
  end

  assign o_dat       = dat_reg;
  assign o_ack       = ack_reg;
  assign o_ram_en    = ram_en_reg;
  assign o_ram_we    = ram_we_reg;
  assign o_ram_addr  = ram_addr_reg;
  assign o_ram_dat   = ram_dat_reg;
  assign o_io_stb    = io_stb_reg;
  assign o_io_we     = io_we_reg;
  assign o_io_addr   = io_addr_reg;
  assign o_io_dat    = io_dat_reg;
  assign o_err_unmap = err_unmap_reg;
  assign o_err_tmo   = err_tmo_reg;

endmodule

// File: tb/tb_dcpu_bus_ctrl.sv
// Testbench for dcpu_bus_ctrl. Two instances run side by side on the same
// stimulus, one with RAM_WAIT=0 and one with RAM_WAIT=2, each with its own
// RAM and IO device model. Expected latencies and data come from a simple
// transaction-level model (region rules, latency formulas, a RAM map).
module tb_dcpu_bus_ctrl;

  localparam int NI  = 2;
  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cs;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic [15:0] io_rdata;
  logic        err_clr;
  int          io_delay;

  logic [1:0][15:0] dat_o;
  logic [1:0]       ack_o, ram_en_o, ram_we_o, io_stb_o, io_we_o, err_unmap_o, err_tmo_o;
  logic [1:0][11:0] ram_addr_o;
  logic [1:0][15:0] ram_dat_o, io_dat_o;
  logic [1:0][7:0]  io_addr_o;

  int checks = 0;
  int errors = 0;

  // observations of the latest access, per instance
  int          obs_lat[NI], obs_ack_n[NI], obs_en[NI], obs_we[NI], obs_stb[NI];
  logic [15:0] obs_dat[NI], obs_hold[NI], obs_io_wdat[NI];
  logic [7:0]  obs_io_addr[NI];
  logic        obs_io_we[NI], obs_eu[NI], obs_et[NI];

  // reference model state
  logic [15:0] model_mem [int];
  int          written[$];
  logic [15:0] last_dat[NI];
  bit          m_eu, m_et;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [15:0] mem [0:4095];
    logic [15:0] ram_q;
    int          stb_age = 0;
    logic        io_ack;

    // synchronous RAM, output held when not enabled
    always @(posedge clk) begin
      if (ram_en_o[gi]) begin
        if (ram_we_o[gi]) mem[ram_addr_o[gi]] <= ram_dat_o[gi];
        else              ram_q <= mem[ram_addr_o[gi]];
      end
    end

    // IO device: acks in the io_delay-th strobe cycle (0 = never)
    always @(posedge clk) stb_age <= io_stb_o[gi] ? stb_age + 1 : 0;
    assign io_ack = io_stb_o[gi] && (io_delay != 0) && (stb_age + 1 == io_delay);

    dcpu_bus_ctrl #(
      .RAM_AW   (12),
      .IO_BASE  (16'hFF00),
      .RAM_WAIT (gi * 2),
      .IO_TMO   (TMO)
    ) u_dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_cs        (cs[gi]),
      .i_we        (we),
      .i_addr      (addr),
      .i_dat       (wdat),
      .o_dat       (dat_o[gi]),
      .o_ack       (ack_o[gi]),
      .o_ram_en    (ram_en_o[gi]),
      .o_ram_we    (ram_we_o[gi]),
      .o_ram_addr  (ram_addr_o[gi]),
      .o_ram_dat   (ram_dat_o[gi]),
      .i_ram_dat   (ram_q),
      .o_io_stb    (io_stb_o[gi]),
      .o_io_we     (io_we_o[gi]),
      .o_io_addr   (io_addr_o[gi]),
      .o_io_dat    (io_dat_o[gi]),
      .i_io_dat    (io_rdata),
      .i_io_ack    (io_ack),
      .i_err_clr   (err_clr),
      .o_err_unmap (err_unmap_o[gi]),
      .o_err_tmo   (err_tmo_o[gi])
    );
  end

  function automatic logic [74:0] all_outs(input int i);
    return {dat_o[i], ack_o[i], ram_en_o[i], ram_we_o[i], ram_addr_o[i], ram_dat_o[i],
            io_stb_o[i], io_we_o[i], io_addr_o[i], io_dat_o[i], err_unmap_o[i], err_tmo_o[i]};
  endfunction

  // Drive one request on both instances and record what each does with it.
  // Each core holds cs through its ACK cycle and drops it one cycle later.
  task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d, input int dly);
    bit fin;
    io_delay = dly;
    for (int i = 0; i < NI; i++) begin
      obs_lat[i] = 0; obs_ack_n[i] = 0; obs_en[i] = 0; obs_we[i] = 0; obs_stb[i] = 0;
      obs_dat[i] = '0; obs_hold[i] = '0; obs_io_wdat[i] = '0; obs_io_addr[i] = '0;
      obs_io_we[i] = 1'b0; obs_eu[i] = 1'b0; obs_et[i] = 1'b0;
    end
    @(negedge clk);
    cs = 2'b11; we = w; addr = a; wdat = d;
    fin = 1'b0;
    for (int k = 1; k <= 80 && !fin; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (obs_lat[i] != 0 && k == obs_lat[i] + 1) begin
          cs[i] = 1'b0;
          obs_hold[i] = dat_o[i];
        end
        obs_en[i] += int'(ram_en_o[i]);
        obs_we[i] += int'(ram_we_o[i]);
        if (io_stb_o[i]) begin
          if (obs_stb[i] == 0) begin
            obs_io_addr[i] = io_addr_o[i];
            obs_io_we[i]   = io_we_o[i];
            obs_io_wdat[i] = io_dat_o[i];
          end
          obs_stb[i]++;
        end
        if (ack_o[i]) begin
          obs_ack_n[i]++;
          if (obs_lat[i] == 0) begin
            obs_lat[i] = k;
            obs_dat[i] = dat_o[i];
            obs_eu[i]  = err_unmap_o[i];
            obs_et[i]  = err_tmo_o[i];
          end
        end
      end
      fin = (obs_lat[0] != 0) && (obs_lat[1] != 0) && (k >= obs_lat[0] + 3) && (k >= obs_lat[1] + 3);
    end
    cs = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 2'b00; we = 1'b0; addr = '0; wdat = '0; err_clr = 1'b0;
    io_rdata = '0; io_delay = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (all_outs(i) !== 75'd0) begin
        errors++; $display("FAIL reset_outputs inst=%0d got=%h exp=0", i, all_outs(i));
      end
      last_dat[i] = '0;
    end
    m_eu = 0; m_et = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram_basic();
    run_access(1'b1, 16'h0010, 16'h1234, 0);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_lat[i] !== 2) begin errors++; $display("FAIL ram_wr_latency inst=%0d got=%0d exp=2", i, obs_lat[i]); end
      checks++; if (obs_we[i] !== 1 || obs_en[i] !== 1) begin errors++; $display("FAIL ram_wr_strobes inst=%0d got en=%0d we=%0d exp en=1 we=1", i, obs_en[i], obs_we[i]); end
    end
    model_mem[16'h0010] = 16'h1234; written.push_back(16'h0010);
    run_access(1'b0, 16'h0010, 16'h0000, 0);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_lat[i] !== 3 + 2 * i) begin errors++; $display("FAIL ram_rd_latency inst=%0d got=%0d exp=%0d", i, obs_lat[i], 3 + 2 * i); end
      checks++; if (obs_dat[i] !== 16'h1234) begin errors++; $display("FAIL ram_rd_data inst=%0d got=%h exp=1234", i, obs_dat[i]); end
      checks++; if (obs_ack_n[i] !== 1 || obs_en[i] !== 1 || obs_we[i] !== 0) begin errors++; $display("FAIL ram_rd_single inst=%0d got acks=%0d en=%0d we=%0d exp 1 1 0", i, obs_ack_n[i], obs_en[i], obs_we[i]); end
      checks++; if (obs_hold[i] !== 16'h1234) begin errors++; $display("FAIL ram_rd_hold inst=%0d got=%h exp=1234", i, obs_hold[i]); end
      last_dat[i] = 16'h1234;
    end
  endtask

  task automatic test_io_read();
    io_rdata = 16'hBEEF;
    run_access(1'b0, 16'hFF05, 16'h0000, 4);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_io_addr[i] !== 8'h05) begin errors++; $display("FAIL io_addr inst=%0d got=%h exp=05", i, obs_io_addr[i]); end
      checks++; if (obs_lat[i] !== 5 || obs_dat[i] !== 16'hBEEF) begin errors++; $display("FAIL io_rd inst=%0d got lat=%0d dat=%h exp lat=5 dat=beef", i, obs_lat[i], obs_dat[i]); end
      checks++; if (obs_et[i] !== 1'b0 || obs_stb[i] !== 4) begin errors++; $display("FAIL io_rd_stb inst=%0d got tmo=%0b stb=%0d exp tmo=0 stb=4", i, obs_et[i], obs_stb[i]); end
      last_dat[i] = 16'hBEEF;
    end
    run_access(1'b1, 16'hFF80, 16'hA5A5, 3);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_io_we[i] !== 1'b1 || obs_io_wdat[i] !== 16'hA5A5 || obs_io_addr[i] !== 8'h80) begin errors++; $display("FAIL io_wr_bus inst=%0d got we=%0b dat=%h addr=%h exp 1 a5a5 80", i, obs_io_we[i], obs_io_wdat[i], obs_io_addr[i]); end
      checks++; if (obs_lat[i] !== 4 || obs_dat[i] !== 16'h0000) begin errors++; $display("FAIL io_wr inst=%0d got lat=%0d dat=%h exp lat=4 dat=0000", i, obs_lat[i], obs_dat[i]); end
      last_dat[i] = 16'h0000;
    end
  endtask

  task automatic test_io_timeout();
    io_rdata = 16'h1357;
    run_access(1'b0, 16'hFF10, 16'h0000, 0);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_stb[i] !== TMO || obs_lat[i] !== TMO + 1) begin errors++; $display("FAIL tmo_timing inst=%0d got stb=%0d lat=%0d exp stb=%0d lat=%0d", i, obs_stb[i], obs_lat[i], TMO, TMO + 1); end
      checks++; if (obs_dat[i] !== 16'hFFFF || obs_et[i] !== 1'b1) begin errors++; $display("FAIL tmo_result inst=%0d got dat=%h tmo=%0b exp ffff 1", i, obs_dat[i], obs_et[i]); end
      last_dat[i] = 16'hFFFF;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++; if (err_tmo_o[i] !== 1'b1) begin errors++; $display("FAIL tmo_sticky inst=%0d got=%0b exp=1", i, err_tmo_o[i]); end
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++; if (err_tmo_o[i] !== 1'b0) begin errors++; $display("FAIL tmo_clear inst=%0d got=%0b exp=0", i, err_tmo_o[i]); end
    end
    m_et = 0;
    run_access(1'b0, 16'hFF11, 16'h0000, TMO);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_lat[i] !== TMO + 1 || obs_dat[i] !== 16'h1357 || obs_et[i] !== 1'b0) begin errors++; $display("FAIL ack_at_expiry inst=%0d got lat=%0d dat=%h tmo=%0b exp lat=%0d dat=1357 tmo=0", i, obs_lat[i], obs_dat[i], obs_et[i], TMO + 1); end
      last_dat[i] = 16'h1357;
    end
  endtask

  task automatic test_unmapped();
    run_access(1'b1, 16'h8000, 16'h5555, 0);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_lat[i] !== 2 || obs_dat[i] !== 16'h0000) begin errors++; $display("FAIL unmap_ack inst=%0d got lat=%0d dat=%h exp lat=2 dat=0000", i, obs_lat[i], obs_dat[i]); end
      checks++; if (obs_eu[i] !== 1'b1 || obs_en[i] !== 0 || obs_stb[i] !== 0) begin errors++; $display("FAIL unmap_side inst=%0d got unmap=%0b en=%0d stb=%0d exp 1 0 0", i, obs_eu[i], obs_en[i], obs_stb[i]); end
      last_dat[i] = 16'h0000;
    end
    m_eu = 1;
  endtask

  task automatic test_reset_mid_io();
    io_delay = 0;
    @(negedge clk);
    cs = 2'b11; we = 1'b0; addr = 16'hFF20; wdat = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++; if (io_stb_o[i] !== 1'b1) begin errors++; $display("FAIL pre_reset_stb inst=%0d got=%0b exp=1", i, io_stb_o[i]); end
    end
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++; if (all_outs(i) !== 75'd0) begin errors++; $display("FAIL async_reset inst=%0d got=%h exp=0", i, all_outs(i)); end
      last_dat[i] = '0;
    end
    m_eu = 0; m_et = 0;
    @(negedge clk); cs = 2'b00; rst = 1'b0;
    io_rdata = 16'h600D;
    run_access(1'b0, 16'hFF21, 16'h0000, 2);
    for (int i = 0; i < NI; i++) begin
      checks++; if (obs_lat[i] !== 3 || obs_dat[i] !== 16'h600D || obs_ack_n[i] !== 1) begin errors++; $display("FAIL after_reset inst=%0d got lat=%0d dat=%h acks=%0d exp 3 600d 1", i, obs_lat[i], obs_dat[i], obs_ack_n[i]); end
      last_dat[i] = 16'h600D;
    end
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic        w;
      logic [15:0] a, d;
      int          dly, kind, rgn;
      int          e_lat, e_en, e_we, e_stb;
      logic [15:0] e_dat;
      kind = $urandom_range(0, 4);
      dly  = $urandom_range(0, TMO + 2);
      d    = 16'($urandom);
      io_rdata = 16'($urandom);
      if (kind == 1 && written.size() == 0) kind = 0;
      case (kind)
        0:       begin w = 1'b1; a = 16'($urandom_range(0, 4095)); end
        1:       begin w = 1'b0; a = 16'(written[$urandom_range(0, written.size() - 1)]); end
        2:       begin w = 1'b0; a = 16'hFF00 + 16'($urandom_range(0, 255)); end
        3:       begin w = 1'b1; a = 16'hFF00 + 16'($urandom_range(0, 255)); end
        default: begin w = 1'($urandom_range(0, 1)); a = 16'($urandom_range(16'h1000, 16'hFEFF)); end
      endcase
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk); err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        m_eu = 0; m_et = 0;
      end
      run_access(w, a, d, dly);
      rgn = (a >= 16'hFF00) ? 2 : (a < 16'd4096) ? 1 : 0;
      if (rgn == 0) m_eu = 1;
      if (rgn == 2 && !(dly >= 1 && dly <= TMO)) m_et = 1;
      for (int i = 0; i < NI; i++) begin
        e_en = 0; e_we = 0; e_stb = 0;
        if (rgn == 1) begin
          e_en = 1; e_we = int'(w);
          e_lat = w ? 2 : 3 + 2 * i;
          e_dat = w ? last_dat[i] : model_mem[int'(a)];
        end else if (rgn == 2) begin
          if (dly >= 1 && dly <= TMO) begin
            e_lat = dly + 1; e_stb = dly; e_dat = w ? 16'h0000 : io_rdata;
          end else begin
            e_lat = TMO + 1; e_stb = TMO; e_dat = 16'hFFFF;
          end
        end else begin
          e_lat = 2; e_dat = 16'h0000;
        end
        checks++; if (obs_lat[i] !== e_lat || obs_ack_n[i] !== 1) begin errors++; $display("FAIL rnd_ack t=%0d inst=%0d addr=%h we=%0b got lat=%0d acks=%0d exp lat=%0d acks=1", t, i, a, w, obs_lat[i], obs_ack_n[i], e_lat); end
        checks++; if (obs_dat[i] !== e_dat || obs_hold[i] !== e_dat) begin errors++; $display("FAIL rnd_data t=%0d inst=%0d addr=%h we=%0b got=%h hold=%h exp=%h", t, i, a, w, obs_dat[i], obs_hold[i], e_dat); end
        checks++; if (obs_en[i] !== e_en || obs_we[i] !== e_we || obs_stb[i] !== e_stb) begin errors++; $display("FAIL rnd_strobes t=%0d inst=%0d got en=%0d we=%0d stb=%0d exp en=%0d we=%0d stb=%0d", t, i, obs_en[i], obs_we[i], obs_stb[i], e_en, e_we, e_stb); end
        checks++; if (obs_eu[i] !== m_eu || obs_et[i] !== m_et) begin errors++; $display("FAIL rnd_errflags t=%0d inst=%0d got unmap=%0b tmo=%0b exp unmap=%0b tmo=%0b", t, i, obs_eu[i], obs_et[i], m_eu, m_et); end
        if (rgn == 2) begin
          checks++; if (obs_io_addr[i] !== a[7:0] || obs_io_we[i] !== w) begin errors++; $display("FAIL rnd_io_bus t=%0d inst=%0d got addr=%h we=%0b exp addr=%h we=%0b", t, i, obs_io_addr[i], obs_io_we[i], a[7:0], w); end
        end
        last_dat[i] = e_dat;
      end
      if (rgn == 1 && w) begin
        model_mem[int'(a)] = d;
        written.push_back(int'(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_io_read();
    test_io_timeout();
    test_unmapped();
    test_reset_mid_io();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
